ucode_datapath: RTL

Parametrised microprogrammed datapath: a bank of NREGS registers of WIDTH bits, a shared source mux with a small ALU stage, and a sequencer that executes a loadable microprogram. It generalises the fixed-FSM, single-bit register/mux datapath. Branches are conditional on register contents, and a start/busy/done handshake connects it to a host controller. It sits under the top-level control block as the reusable execution engine for generated datapaths.

---
 rtl/ucode_datapath.sv | 156 +++++++++++++++
 1 files changed

// File: rtl/ucode_datapath.sv
// Microprogrammed datapath: NREGS x WIDTH register bank, source mux + small ALU,
// and a sequencer running a loadable microprogram with a start/busy/done handshake.
module ucode_datapath #(
    parameter int WIDTH = 8,
    parameter int NREGS = 4,
    parameter int DEPTH = 8,
    localparam int SW = $clog2(NREGS + 1),
    localparam int CW = $clog2(NREGS),
    localparam int AW = $clog2(DEPTH),
    localparam int UW = NREGS + SW + 2 + 2 + CW + AW
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] din,
    input  logic             prog_we,
    input  logic [AW-1:0]    prog_addr,
    input  logic [UW-1:0]    prog_data,
    output logic [WIDTH-1:0] dout,
    output logic [AW-1:0]    upc,
    output logic             busy,
    output logic             done
);
    localparam int TGT_LSB  = 0;
    localparam int COND_LSB = AW;
    localparam int SEQ_LSB  = AW + CW;
    localparam int OP_LSB   = SEQ_LSB + 2;
    localparam int SRC_LSB  = OP_LSB + 2;
    localparam int LD_LSB   = SRC_LSB + SW;

    typedef enum logic {ST_IDLE, ST_RUN} state_t;

    state_t            state_q;
    logic [AW-1:0]     upc_q, upc_d;
    logic              done_q;

    logic [UW-1:0]     mem [DEPTH];
    logic [UW-1:0]     uword;
    logic [NREGS-1:0]  uw_ld;
    logic [SW-1:0]     uw_src;
    logic [1:0]        uw_op;
    logic [1:0]        uw_seq;
    logic [CW-1:0]     uw_cond;
    logic [AW-1:0]     uw_tgt;

    logic [WIDTH-1:0]  regs_view [NREGS];
    logic [WIDTH-1:0]  bus_tab [2**SW];
    logic [2**CW-1:0]  cond_tab;
    logic [WIDTH-1:0]  bus_val;
    logic [WIDTH-1:0]  alu_res;
    logic              run;
    logic              halt;

    always_ff @(posedge clk) begin
        if (prog_we && state_q == ST_IDLE) begin
            mem[prog_addr] <= prog_data;
        end
    end

    // Asynchronous read so a word written alongside start is seen in the first RUN cycle.
    assign uword   = mem[upc_q];
    assign uw_ld   = uword[LD_LSB +: NREGS];
    assign uw_src  = uword[SRC_LSB +: SW];
    assign uw_op   = uword[OP_LSB +: 2];
    assign uw_seq  = uword[SEQ_LSB +: 2];
    assign uw_cond = uword[COND_LSB +: CW];
    assign uw_tgt  = uword[TGT_LSB +: AW];

    assign run  = (state_q == ST_RUN);
    assign halt = (uw_seq == 2'b11);

    // Tables padded to the full index range so out-of-range selectors read zero.
    for (genvar gi = 0; gi < 2**SW; gi++) begin : gen_bus
        if (gi < NREGS) begin : g_reg
            assign bus_tab[gi] = regs_view[gi];
        end else if (gi == NREGS) begin : g_din
            assign bus_tab[gi] = din;
        end else begin : g_zero
            assign bus_tab[gi] = '0;
        end
    end

    for (genvar gi = 0; gi < 2**CW; gi++) begin : gen_cond
        if (gi < NREGS) begin : g_reg
            assign cond_tab[gi] = regs_view[gi][0];
        end else begin : g_zero
            assign cond_tab[gi] = 1'b0;
        end
    end

    assign bus_val = bus_tab[uw_src];

    always_comb begin
        alu_res = bus_val;
        case (uw_op)
            2'b01:   alu_res = bus_val + WIDTH'(1);
            2'b10:   alu_res = '0;
            default: alu_res = bus_val;
        endcase
    end

    always_comb begin
        upc_d = upc_q + AW'(1);
        case (uw_seq)
            2'b01:   upc_d = uw_tgt;
            2'b10:   if (cond_tab[uw_cond]) upc_d = uw_tgt;
            default: upc_d = upc_q + AW'(1);
        endcase
    end

    for (genvar gi = 0; gi < NREGS; gi++) begin : gen_reg
        logic [WIDTH-1:0] r_q;
        always_ff @(posedge clk) begin
            if (rst) begin
                r_q <= '0;
            end else if (run && uw_ld[gi]) begin
                r_q <= alu_res;
            end
        end
        assign regs_view[gi] = r_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_IDLE;
            upc_q   <= '0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    done_q <= 1'b0;
                    if (start) begin
                        state_q <= ST_RUN;
                        upc_q   <= '0;
                    end
                end
                default: begin
                    if (halt) begin
                        state_q <= ST_IDLE;
                        upc_q   <= '0;
                        done_q  <= 1'b1;
                    end else begin
                        upc_q   <= upc_d;
                        done_q  <= 1'b0;
                    end
                end
            endcase
        end
    end

    assign dout = regs_view[NREGS-1];
    assign upc  = upc_q;
    assign busy = run;
    assign done = done_q;

endmodule
